bias_add_unit: RTL and testbench

- Downstream consumer of the bias loader; reads bias lines from the bias buffer B port, which the loader fills.
- Adds the bias lines lane-wise to a 512-bit result stream: 16 signed 32-bit lanes per beat.
- Optional ReLU on each lane; drives the biased result stream to the write-back stage.
- One instruction per ap_start; one ap_done pulse when the last output beat is accepted.

---
 rtl/bias_add_unit_pkg.sv | 43 ++++
 rtl/bias_add_unit_if.sv | 26 ++
 rtl/bias_add_unit_lane_adder.sv | 21 ++
 rtl/bias_add_unit.sv | 188 ++++++++++++++++++
 tb/tb_bias_add_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bias_add_unit_pkg.sv
// Shared constants, instruction decode and FSM encoding for the bias add unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bias_add_unit_pkg;

    localparam int BIAS_INST_LENGTH   = 96;
    localparam int C_M_AXI_DATA_WIDTH = 512;
    localparam int C_ADDER_BIT_WIDTH  = 32;
    localparam int BUF_ADDR_WIDTH     = 9;
    localparam int LANES              = C_M_AXI_DATA_WIDTH / C_ADDER_BIT_WIDTH;

    // Instruction field offsets
    localparam int BASE_LSB = 0;
    localparam int L_LSB    = 16;
    localparam int R_LSB    = 32;
    localparam int RELU_BIT = 48;
    localparam int FIELD_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [BUF_ADDR_WIDTH-1:0] base;
        logic [FIELD_W-1:0]        len;
        logic [FIELD_W-1:0]        rows;
        logic                      relu;
    } inst_t;

    // Only the low BUF_ADDR_WIDTH bits of the base field address the buffer.
    function automatic inst_t decode_inst(input logic [BIAS_INST_LENGTH-1:0] inst);
        inst_t r;
        r.base = inst[BASE_LSB +: BUF_ADDR_WIDTH];
        r.len  = inst[L_LSB +: FIELD_W];
        r.rows = inst[R_LSB +: FIELD_W];
        r.relu = inst[RELU_BIT];
        return r;
    endfunction

endpackage

// File: rtl/bias_add_unit_if.sv
// Valid/ready result stream carrying one 512-bit line per beat.
// Latency: n/a (wires only).
// Backpressure: beat transfers only when tvalid && tready.
interface bias_add_unit_if;
    import bias_add_unit_pkg::*;

    logic                          tvalid;
    logic                          tready;
    logic [C_M_AXI_DATA_WIDTH-1:0] tdata;
    logic                          tlast;

    // Producer side
    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    // Consumer side; row framing is regenerated by the bias unit, so tlast is not consumed
    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/bias_add_unit_lane_adder.sv
// One 32-bit lane: wrapping two's-complement add with optional ReLU clamp.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
module bias_lane_adder
    import bias_add_unit_pkg::*;
(
    input  logic [C_ADDER_BIT_WIDTH-1:0] a_dat,
    input  logic [C_ADDER_BIT_WIDTH-1:0] b_dat,
    input  logic                         relu_en,
    output logic [C_ADDER_BIT_WIDTH-1:0] y_dat
);

    logic [C_ADDER_BIT_WIDTH-1:0] sum_dat;

    // Wrap-around add, then clamp negative sums to zero when ReLU is on
    always_comb begin
        sum_dat = a_dat + b_dat;
        y_dat   = (relu_en && sum_dat[C_ADDER_BIT_WIDTH-1]) ? '0 : sum_dat;
    end

endmodule

// File: rtl/bias_add_unit.sv
// Adds a bias buffer line lane-wise to each result beat, optional ReLU, per-row tlast.
// Latency: input handshake at cycle t gives out_tvalid at t+2; 1 beat/cycle sustained.
// Backpressure: out_tready low stalls stage 1 and drops in_tready; bias reads pause with it.
module bias_add_unit
    import bias_add_unit_pkg::*;
(
    input  logic                          kernel_clk,
    input  logic                          kernel_rst,
    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [BIAS_INST_LENGTH-1:0]   ctrl_instruction,
    output logic                          bias_read_buffer_b_en,
    output logic [BUF_ADDR_WIDTH-1:0]     bias_read_buffer_b_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] bias_read_buffer_b_data,
    bias_add_unit_if.slave                in_s,
    bias_add_unit_if.master               out_m
);

    localparam int W  = C_ADDER_BIT_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    state_e                    state_q, state_d;
    logic [BUF_ADDR_WIDTH-1:0] base_q, base_d;
    logic [FIELD_W-1:0]        len_q, len_d;
    logic [FIELD_W-1:0]        rows_q, rows_d;
    logic                      relu_q, relu_d;
    logic [FIELD_W-1:0]        col_q, col_d;
    logic [FIELD_W-1:0]        row_q, row_d;

    // Stage 1: input beat waiting for its bias line (which arrives one cycle after b_en)
    logic                      v1_q, v1_d;
    logic [DW-1:0]             d1_q, d1_d;
    logic                      tlast1_q, tlast1_d;

    // Output register
    logic                      ovld_q, ovld_d;
    logic [DW-1:0]             odat_q, odat_d;
    logic                      olast_q, olast_d;

    inst_t                     inst_w;
    logic [DW-1:0]             sum_w;
    logic                      in_rdy;
    logic                      in_hs;
    logic                      adv;
    logic                      out_hs;
    logic                      last_col;
    logic                      last_row;

    assign inst_w = decode_inst(ctrl_instruction);

    // Sixteen independent lane adders fed by stage 1 and the bias read data
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bias_lane_adder u_lane (
            .a_dat   (d1_q[i*W +: W]),
            .b_dat   (bias_read_buffer_b_data[i*W +: W]),
            .relu_en (relu_q),
            .y_dat   (sum_w[i*W +: W])
        );
    end

    // Handshake qualifiers shared by the FSM, pipeline and buffer read port
    always_comb begin
        in_rdy   = (state_q == ST_RUN) && (!v1_q || !ovld_q || out_m.tready);
        in_hs    = in_rdy && in_s.tvalid;
        adv      = v1_q && (!ovld_q || out_m.tready);
        out_hs   = ovld_q && out_m.tready;
        last_col = (col_q == len_q - 16'd1);
        last_row = (row_q == rows_q - 16'd1);
    end

    // Next-state, instruction latch and beat counters
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        rows_d  = rows_q;
        relu_d  = relu_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    base_d  = inst_w.base;
                    len_d   = inst_w.len;
                    rows_d  = inst_w.rows;
                    relu_d  = inst_w.relu;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = (inst_w.len == '0 || inst_w.rows == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_hs) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                        if (last_row) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Only the final beat can be in the output register once stage 1 is empty
                if (!v1_q && out_hs && olast_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Two-stage data pipeline: capture into stage 1, then add bias into the output register
    always_comb begin
        v1_d     = v1_q;
        d1_d     = d1_q;
        tlast1_d = tlast1_q;
        ovld_d   = ovld_q;
        odat_d   = odat_q;
        olast_d  = olast_q;
        if (in_hs) begin
            v1_d     = 1'b1;
            d1_d     = in_s.tdata;
            tlast1_d = last_col;
        end else if (adv) begin
            v1_d = 1'b0;
        end
        if (adv) begin
            ovld_d  = 1'b1;
            odat_d  = sum_w;
            olast_d = tlast1_q;
        end else if (out_hs) begin
            ovld_d = 1'b0;
        end
    end

    // State and pipeline registers
    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            rows_q   <= '0;
            relu_q   <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            v1_q     <= 1'b0;
            d1_q     <= '0;
            tlast1_q <= 1'b0;
            ovld_q   <= 1'b0;
            odat_q   <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            rows_q   <= rows_d;
            relu_q   <= relu_d;
            col_q    <= col_d;
            row_q    <= row_d;
            v1_q     <= v1_d;
            d1_q     <= d1_d;
            tlast1_q <= tlast1_d;
            ovld_q   <= ovld_d;
            odat_q   <= odat_d;
            olast_q  <= olast_d;
        end
    end

    // Output drive; buffer is read only on an accepted beat so stalls hold the read data
    always_comb begin
        ap_done                 = (state_q == ST_DONE);
        in_s.tready             = in_rdy;
        bias_read_buffer_b_en   = in_hs;
        bias_read_buffer_b_addr = in_hs ? (base_q + col_q[BUF_ADDR_WIDTH-1:0]) : '0;
        out_m.tvalid            = ovld_q;
        out_m.tdata             = odat_q;
        out_m.tlast             = olast_q;
    end

endmodule

// File: tb/tb_bias_add_unit.sv
module tb_bias_add_unit;
    import bias_add_unit_pkg::*;

    logic         kernel_clk;
    logic         kernel_rst;
    logic         ap_start;
    logic         ap_done;
    logic [95:0]  ctrl_instruction;
    logic         b_en;
    logic [8:0]   b_addr;
    logic [511:0] b_data;

    bias_add_unit_if in_if ();
    bias_add_unit_if out_if ();

    bias_add_unit dut (
        .kernel_clk              (kernel_clk),
        .kernel_rst              (kernel_rst),
        .ap_start                (ap_start),
        .ap_done                 (ap_done),
        .ctrl_instruction        (ctrl_instruction),
        .bias_read_buffer_b_en   (b_en),
        .bias_read_buffer_b_addr (b_addr),
        .bias_read_buffer_b_data (b_data),
        .in_s                    (in_if),
        .out_m                   (out_if)
    );

    initial kernel_clk = 1'b0;
    always #5 kernel_clk = ~kernel_clk;

    // Bias buffer B port: one-cycle read latency, data held while en is low
    logic [511:0] bias_mem [512];
    always @(posedge kernel_clk) begin
        if (b_en) b_data <= bias_mem[b_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] fill(input logic [31:0] v);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [511:0] ramp(input int s, input int st);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(s + i * st);
        return r;
    endfunction

    logic [511:0] beats[$];
    logic [511:0] expd[$];
    bit           expl[$];
    logic [8:0]   expa[$];
    int first_in, first_out, first_ohs, last_out, done_cyc, n_out, n_ben, n_rdy;

    task automatic run_inst(input logic [15:0] base, input logic [15:0] len, input logic [15:0] rows,
                            input bit relu, input bit rnd, input string tag);
        int  sent;
        int  cyc;
        bit  done;
        logic [511:0] e;
        sent = 0; cyc = 0; done = 0;
        first_in = -1; first_out = -1; first_ohs = -1; last_out = -1; done_cyc = -1;
        n_out = 0; n_ben = 0; n_rdy = 0;
        @(posedge kernel_clk); #1;
        ctrl_instruction = '0;
        ctrl_instruction[15:0]  = base;
        ctrl_instruction[31:16] = len;
        ctrl_instruction[47:32] = rows;
        ctrl_instruction[48]    = relu;
        ap_start     = 1'b1;
        in_if.tvalid = (beats.size() > 0);
        in_if.tdata  = (beats.size() > 0) ? beats[0] : '0;
        out_if.tready = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge kernel_clk);
            if (ap_done) begin done = 1; done_cyc = cyc; end
            if (in_if.tready) n_rdy++;
            if (b_en) begin
                n_ben++;
                if (expa.size() > 0) chk({tag, "_addr"}, b_addr, expa.pop_front());
                else chk({tag, "_extra_ben"}, 1, 0);
            end
            if (in_if.tvalid && in_if.tready) begin
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            if (out_if.tvalid && first_out < 0) first_out = cyc;
            if (out_if.tvalid && out_if.tready) begin
                if (first_ohs < 0) first_ohs = cyc;
                last_out = cyc;
                n_out++;
                if (expd.size() > 0) begin
                    e = expd.pop_front();
                    chk({tag, "_dat"}, out_if.tdata, e);
                    chk({tag, "_last"}, out_if.tlast, expl.pop_front());
                end else begin
                    chk({tag, "_extra_beat"}, 1, 0);
                end
            end
            @(posedge kernel_clk); #1;
            ap_start = 1'b0;
            cyc++;
            in_if.tvalid = (sent < beats.size());
            if (sent < beats.size()) in_if.tdata = beats[sent];
            out_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!done) chk({tag, "_timeout"}, 0, 1);
        @(negedge kernel_clk);
        chk({tag, "_done_pulse"}, ap_done, 0);
        in_if.tvalid = 1'b0;
        beats.delete(); expd.delete(); expl.delete(); expa.delete();
    endtask

    task automatic load_t1();
        beats.push_back(fill(10)); beats.push_back(fill(20));
        expd.push_back(fill(11));  expd.push_back(fill(22));
        expl.push_back(0);         expl.push_back(1);
        expa.push_back(9'd0);      expa.push_back(9'd1);
    endtask

    logic [511:0] v, bv;

    initial begin
        for (int i = 0; i < 512; i++) bias_mem[i] = '0;
        kernel_rst = 1'b1; ap_start = 1'b0; ctrl_instruction = '0;
        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tlast = 1'b0; out_if.tready = 1'b0;
        b_data = '0;

        // Bias buffer contents used by the vectors below
        bias_mem[0] = fill(1); bias_mem[1] = fill(2);
        bias_mem[510] = fill(5); bias_mem[511] = fill(6);
        for (int c = 0; c < 16; c++) bias_mem[12 + c] = fill(32'h1000 + 32'(c));
        for (int c = 0; c < 4; c++) bias_mem[100 + c] = ramp(c * 100 - 30, 7);
        bv = '0; bv[31:0] = 32'd3; bv[63:32] = 32'd1; bv[95:64] = 32'd3;
        bias_mem[40] = bv;

        repeat (2) @(posedge kernel_clk);
        @(negedge kernel_clk);
        chk("rst_done", ap_done, 0);
        chk("rst_ovld", out_if.tvalid, 0);
        chk("rst_irdy", in_if.tready, 0);
        chk("rst_ben", b_en, 0);
        chk("rst_odat", out_if.tdata, 0);
        kernel_rst = 1'b0;

        // Basic two-beat row
        load_t1();
        run_inst(16'd0, 16'd2, 16'd1, 1'b0, 1'b0, "t1");
        chk("t1_nout", n_out, 2);
        chk("t1_lat", first_out - first_in, 2);
        chk("t1_done_lat", done_cyc - last_out, 1);

        // Three rows of 16 at full rate
        for (int j = 0; j < 48; j++) begin
            beats.push_back(fill(32'(j * 3)));
            expd.push_back(fill(32'(j * 3) + 32'h1000 + 32'(j % 16)));
            expl.push_back((j % 16) == 15);
            expa.push_back(9'(12 + (j % 16)));
        end
        run_inst(16'd12, 16'd16, 16'd3, 1'b0, 1'b0, "t2");
        chk("t2_nout", n_out, 48);
        chk("t2_nben", n_ben, 48);
        chk("t2_rate", last_out - first_ohs, 47);

        // ReLU on: -5+3 -> 0, 0x7FFFFFFF+1 -> 0, 5+3 -> 8
        v = '0; v[31:0] = 32'hFFFF_FFFB; v[63:32] = 32'h7FFF_FFFF; v[95:64] = 32'd5;
        beats.push_back(v);
        bv = '0; bv[95:64] = 32'd8;
        expd.push_back(bv); expl.push_back(1); expa.push_back(9'd40);
        run_inst(16'd40, 16'd1, 16'd1, 1'b1, 1'b0, "relu1");

        // ReLU off: same sums wrap
        beats.push_back(v);
        bv = '0; bv[31:0] = 32'hFFFF_FFFE; bv[63:32] = 32'h8000_0000; bv[95:64] = 32'd8;
        expd.push_back(bv); expl.push_back(1); expa.push_back(9'd40);
        run_inst(16'd40, 16'd1, 16'd1, 1'b0, 1'b0, "relu0");

        // Address wrap at the top of the buffer
        for (int k = 0; k < 4; k++) beats.push_back(fill(32'(100 + k)));
        expd.push_back(fill(105)); expd.push_back(fill(107));
        expd.push_back(fill(103)); expd.push_back(fill(105));
        for (int k = 0; k < 4; k++) expl.push_back(k == 3);
        expa.push_back(9'd510); expa.push_back(9'd511); expa.push_back(9'd0); expa.push_back(9'd1);
        run_inst(16'd510, 16'd4, 16'd1, 1'b0, 1'b0, "wrap");
        chk("wrap_nout", n_out, 4);

        // Random backpressure, 4x4
        for (int j = 0; j < 16; j++) begin
            beats.push_back(ramp(-(j * 50), 3));
            expd.push_back(ramp((j % 4) * 100 - 30 - j * 50, 10));
            expl.push_back((j % 4) == 3);
            expa.push_back(9'(100 + (j % 4)));
        end
        run_inst(16'd100, 16'd4, 16'd4, 1'b0, 1'b1, "bp");
        chk("bp_nout", n_out, 16);
        chk("bp_nben", n_ben, 16);

        // Zero-length instruction
        run_inst(16'd0, 16'd0, 16'd5, 1'b0, 1'b0, "l0");
        chk("l0_done_lat", done_cyc, 1);
        chk("l0_nben", n_ben, 0);
        chk("l0_nrdy", n_rdy, 0);

        // Reset in the middle of a run
        @(posedge kernel_clk); #1;
        ctrl_instruction = '0;
        ctrl_instruction[31:16] = 16'd4;
        ctrl_instruction[47:32] = 16'd4;
        ap_start = 1'b1;
        out_if.tready = 1'b0;
        @(posedge kernel_clk); #1;
        ap_start = 1'b0;
        in_if.tvalid = 1'b1; in_if.tdata = fill(7);
        repeat (2) @(posedge kernel_clk);
        #2;
        chk("mid_pre_vld", out_if.tvalid, 1);
        kernel_rst = 1'b1;
        #1;
        chk("mid_ovld", out_if.tvalid, 0);
        chk("mid_odat", out_if.tdata, 0);
        chk("mid_olast", out_if.tlast, 0);
        chk("mid_irdy", in_if.tready, 0);
        chk("mid_ben", b_en, 0);
        chk("mid_done", ap_done, 0);
        in_if.tvalid = 1'b0;
        out_if.tready = 1'b1;
        repeat (2) @(posedge kernel_clk);
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        n_out = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge kernel_clk);
            if (ap_done || out_if.tvalid || in_if.tready) n_out++;
        end
        chk("mid_quiet", n_out, 0);

        // Clean run after reset
        load_t1();
        run_inst(16'd0, 16'd2, 16'd1, 1'b0, 1'b0, "t1b");
        chk("t1b_nout", n_out, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
